// File: rtl/vmem1_map_pkg.sv
// Shared constants, field positions and FSM state type for the level-2 map stage.
// No logic of its own.
// No flow control of its own.
package vmem1_map_pkg;

  localparam int VMAP_W         = 5;
  localparam int MAPI_W         = 5;
  localparam int VMA_W          = 24;
  localparam int PPN_W          = 14;
  localparam int L2_MAP_DEPTH   = 1024;

  // Map word layout
  localparam int VMO_ACCESS_BIT = 23;
  localparam int VMO_WRITE_BIT  = 22;
  localparam int VMO_PPN_MSB    = 13;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/vmem1_map_if.sv
// Bus bundle between the memory control logic (master) and the level-2 map (slave).
// Outputs are registered in the slave, with one cycle of read latency.
// No flow control: strobes are single-cycle and are dropped while rdy is low.
interface vmem1_map_if;
  import vmem1_map_pkg::*;

  logic [VMAP_W-1:0] vmap;
  logic [MAPI_W-1:0] mapi;
  logic [VMA_W-1:0]  vma;
  logic              vm1rp;
  logic              vm1wp;
  logic              memchk;
  logic              memwr;
  logic [VMA_W-1:0]  vmo;
  logic [PPN_W-1:0]  pma;
  logic              pfr;
  logic              pfw;
  logic              rdy;

  modport master (
    output vmap, mapi, vma, vm1rp, vm1wp, memchk, memwr,
    input  vmo, pma, pfr, pfw, rdy
  );

  modport slave (
    input  vmap, mapi, vma, vm1rp, vm1wp, memchk, memwr,
    output vmo, pma, pfr, pfw, rdy
  );

endinterface

// File: rtl/vmem1_ram.sv
// Single-port synchronous RAM holding the level-2 map words.
// One cycle read latency; the read register holds while the read enable is low.
// No backpressure: every write and read-enable is accepted on its edge.
module vmem1_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array: no reset, contents are made defined by the parent's clear sweep
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Output register: reset so the map word is never X, otherwise holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vmem1_map.sv
// Level-2 virtual memory map: indexes a 1024-entry map with {vmap, mapi}, returns word, page and faults.
// Read data and fault flags appear one cycle after the read strobe; writes land at the strobe edge.
// Strobes are ignored until the post-reset clear sweep finishes and rdy is high.
module vmem1_map
  import vmem1_map_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 24,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         reset,
  vmem1_map_if.slave   bus
);

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic   RESET_RDY   = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  w_clr_en;
  logic                  r_rdy;
  logic                  r_chk;
  logic                  r_wr;

  logic [ADDR_WIDTH-1:0] w_adr;
  logic                  w_run_wr;
  logic                  w_run_rd;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_adr = {bus.vmap, bus.mapi};

  // Strobes only act once the map is usable; write takes priority over read
  assign w_run_wr = r_rdy & bus.vm1wp;
  assign w_run_rd = r_rdy & bus.vm1rp & ~bus.vm1wp;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: sweep every entry once, then run
  always_comb begin
    w_state_nxt = r_state;
    w_clr_en    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_en = 1'b1;
        if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  // Sweep address counter; wraps to 0 after the last entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (w_clr_en) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // rdy trails entry into RUN by one edge so the last cleared entry is settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy <= RESET_RDY;
    end else begin
      r_rdy <= (r_state == RUN);
    end
  end

  // Capture the permission-check qualifiers alongside each read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chk <= 1'b0;
      r_wr  <= 1'b0;
    end else if (w_run_rd) begin
      r_chk <= bus.memchk;
      r_wr  <= bus.memwr;
    end
  end

  // Clear mux: the sweep owns the RAM port while it runs
  always_comb begin
    w_ram_addr  = w_adr;
    w_ram_we    = w_run_wr;
    w_ram_wdata = bus.vma;
    if (w_clr_en) begin
      w_ram_addr  = r_clr_cnt;
      w_ram_we    = 1'b1;
      w_ram_wdata = '0;
    end
  end

  vmem1_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (w_ram_wdata),
    .i_re    (w_run_rd),
    .o_rdata (w_ram_rdata)
  );

  // Faults derive from the registered word and registered qualifiers, so they
  // change only on read-capture edges exactly like a registered flag would.
  assign bus.vmo = w_ram_rdata;
  assign bus.pma = w_ram_rdata[VMO_PPN_MSB:0];
  assign bus.pfr = r_chk & ~w_ram_rdata[VMO_ACCESS_BIT];
  assign bus.pfw = r_chk & r_wr & w_ram_rdata[VMO_ACCESS_BIT] & ~w_ram_rdata[VMO_WRITE_BIT];
  assign bus.rdy = r_rdy;

endmodule
